// File: rtl/home_auto_pkg.sv
// home_auto_pkg: shared codes, scheduler state and request-vector type for the actuator scheduler.
package home_auto_pkg;
  localparam logic [2:0] CODE_IDLE = 3'd0, CODE_FRONT_DOOR = 3'd1, CODE_REAR_DOOR = 3'd2, CODE_ALARM = 3'd3;
  localparam logic [2:0] CODE_WINDOW = 3'd4, CODE_HEATER = 3'd5, CODE_COOLER = 3'd6;
  typedef enum logic [1:0] {IDLE, SERVE, GAP} sched_state_t;
  typedef logic [6:1] req_t;
  // Round-robin ring holds codes 1,2,4,5,6; alarm sits between rear door and window.
  function automatic logic [2:0] rr_slot(input logic [2:0] c);
    rr_slot = c <= 3'd2 ? c - 3'd1 : c == CODE_ALARM ? 3'd1 : c - 3'd2;
  endfunction
  function automatic logic [2:0] slot_code(input logic [2:0] s);
    slot_code = s <= 3'd1 ? s + 3'd1 : s + 3'd2;
  endfunction
endpackage

// File: rtl/rr_arbiter5.sv
// rr_arbiter5: one-hot grant of the first request strictly after position ptr, searching circularly.
module rr_arbiter5 (
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [4:0] gnt
);
  always_comb begin
    gnt = '0;
    for (int k = 5; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % 5]) gnt = 5'(1) << ((int'(ptr) + k) % 5);
    end
  end
endmodule

// File: rtl/actuator_scheduler.sv
// actuator_scheduler: drives one home actuator at a time, alarm first, others round-robin with dwell and gap.
// Define ALARM_PREEMPT_EN to let a pending alarm cut a non-alarm slot short.
module actuator_scheduler import home_auto_pkg::*; #(
  parameter int DWELL = 4,
  parameter int GAP = 1,
  parameter int TEMP_LOW = 10,
  parameter int TEMP_HIGH = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SFD,
  input  logic       SRD,
  input  logic       SFA,
  input  logic       SW,
  input  logic       ST,
  input  logic [5:0] temperature,
  output logic [2:0] code,
  output logic       front_door,
  output logic       rear_door,
  output logic       alarm_buzzer,
  output logic       window_buzzer,
  output logic       heater,
  output logic       cooler,
  output logic       busy,
  output logic       slot_done
);
  localparam int TW = $clog2((DWELL > GAP ? DWELL : GAP) + 1);
  sched_state_t state;
  req_t rq, pending, clr, src;
  logic [2:0] rr_ptr, sel;
  logic [4:0] gnt;
  logic [TW-1:0] timer;
  logic done, preempt;
  assign rq = {ST & (temperature > 6'(TEMP_HIGH)), ST & (temperature < 6'(TEMP_LOW)), SW, SFA, SRD, SFD};
  assign done = state == SERVE && timer == '0 && (code != CODE_ALARM || !SFA);
  assign clr = done ? 6'd1 << (code - 3'd1) : 6'd0;
  assign src = pending & ~clr;
`ifdef ALARM_PREEMPT_EN
  assign preempt = state == SERVE && code != CODE_ALARM && pending[3] && !done;
`else
  assign preempt = 1'b0;
`endif
  // On a gapless slot end the next grant is chosen relative to the code just served.
  rr_arbiter5 u_arb (
    .req({src[6], src[5], src[4], src[2], src[1]}),
    .ptr(rr_slot(state == SERVE ? code : rr_ptr)),
    .gnt(gnt)
  );
  always_comb begin
    sel = src[3] ? CODE_ALARM : CODE_IDLE;
    for (int s = 0; s < 5; s++) if (!src[3] && gnt[s]) sel = slot_code(3'(s));
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      code <= CODE_IDLE;
      timer <= '0;
      pending <= '0;
      rr_ptr <= CODE_FRONT_DOOR;
    end else begin
      pending <= rq | src;
      if (done) rr_ptr <= code;
      if (preempt) begin
        code <= CODE_ALARM;
        timer <= TW'(DWELL - 1);
      end else if (state == SERVE && !done) timer <= timer - TW'(timer != '0);
      else if (done && GAP > 0) begin
        state <= home_auto_pkg::GAP;
        code <= CODE_IDLE;
        timer <= TW'(GAP - 1);
      end else if (state == home_auto_pkg::GAP && timer != '0) timer <= timer - TW'(1);
      else begin
        state <= sel != CODE_IDLE ? SERVE : IDLE;
        code <= sel;
        timer <= sel != CODE_IDLE ? TW'(DWELL - 1) : '0;
      end
    end
  assign front_door = code == CODE_FRONT_DOOR;
  assign rear_door = code == CODE_REAR_DOOR;
  assign alarm_buzzer = code == CODE_ALARM;
  assign window_buzzer = code == CODE_WINDOW;
  assign heater = code == CODE_HEATER;
  assign cooler = code == CODE_COOLER;
  assign busy = state != IDLE;
  assign slot_done = done;
endmodule
